// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router input-side sequencer.
package router_pkg;

  localparam int NPORT = 3;
  localparam int ADDR_W = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  localparam int TIMEOUT_DEF = 30;
  localparam int CNT_W_DEF = 5;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_e;

endpackage

// File: rtl/router_timeout_ctr.sv
// Per-port read timeout: pulses soft_rst for one cycle after TIMEOUT
// consecutive cycles of vld without rd.
module router_timeout_ctr #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic rd,
  output logic soft_rst
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      soft_rst <= 1'b0;
    end else if (!vld || rd) begin
      cnt      <= '0;
      soft_rst <= 1'b0;
    end else if (cnt == LAST) begin
      cnt      <= '0;
      soft_rst <= 1'b1;
    end else begin
      cnt      <= cnt + 1'b1;
      soft_rst <= 1'b0;
    end
  end

endmodule

// File: rtl/router_fsm_ctrl.sv
// Router input-side packet sequencer with per-port read timeouts.
// Define ROUTER_ADDR_ERR_EN to add the addr_err pulse for invalid headers.
module router_fsm_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic [NPORT-1:0]  fifo_full_in,
  input  logic [NPORT-1:0]  fifo_empty,
  input  logic [NPORT-1:0]  read_enb,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic [NPORT-1:0]  write_enb,
  output logic              fifo_full,
  output logic              busy,
  output logic [NPORT-1:0]  vld_out,
  output logic [NPORT-1:0]  soft_reset
`ifdef ROUTER_ADDR_ERR_EN
  ,
  output logic              addr_err
`endif
);

  state_e            state;
  state_e            next_state;
  logic [ADDR_W-1:0] sel;
  logic              hdr_ok;

  assign hdr_ok = pkt_valid && (data_in != ADDR_INVALID);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DECODE_ADDRESS;
      sel   <= '0;
    end else begin
      state <= next_state;
      if (state == DECODE_ADDRESS && hdr_ok) sel <= data_in;
    end
  end

  // NOTE: next_state defaults to the current state first, so no path infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      DECODE_ADDRESS:
        if (hdr_ok) next_state = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      WAIT_TILL_EMPTY:
        if (fifo_empty[sel]) next_state = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:
        next_state = LOAD_DATA;
      LOAD_DATA:
        if (fifo_full)       next_state = FIFO_FULL_STATE;
        else if (!pkt_valid) next_state = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!fifo_full) next_state = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (parity_done)        next_state = DECODE_ADDRESS;
        else if (low_pkt_valid) next_state = LOAD_PARITY;
        else                    next_state = LOAD_DATA;
      LOAD_PARITY:
        next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:
        next_state = DECODE_ADDRESS;
    endcase
    // A flushed destination FIFO abandons the packet in flight.
    if (state != DECODE_ADDRESS && soft_reset[sel]) next_state = DECODE_ADDRESS;
  end

  assign detect_add  = (state == DECODE_ADDRESS);
  assign lfd_state   = (state == LOAD_FIRST_DATA);
  assign ld_state    = (state == LOAD_DATA);
  assign laf_state   = (state == LOAD_AFTER_FULL);
  assign full_state  = (state == FIFO_FULL_STATE);
  assign rst_int_reg = (state == CHECK_PARITY_ERROR);

  assign write_enb_reg = ld_state || laf_state || (state == LOAD_PARITY);
  assign busy          = !(detect_add || ld_state);
  assign write_enb     = write_enb_reg ? (3'b001 << sel) : 3'b000;
  assign fifo_full     = fifo_full_in[sel];
  assign vld_out       = ~fifo_empty;

  for (genvar i = 0; i < NPORT; i++) begin : g_tmo
    router_timeout_ctr #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_tmo (
      .clk      (clk),
      .rst      (rst),
      .vld      (vld_out[i]),
      .rd       (read_enb[i]),
      .soft_rst (soft_reset[i])
    );
  end

`ifdef ROUTER_ADDR_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) addr_err <= 1'b0;
    else     addr_err <= detect_add && pkt_valid && (data_in == ADDR_INVALID);
  end
`else
  // Invalid headers are dropped silently; the FSM simply stays in DECODE_ADDRESS.
`endif

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Self-checking bench for router_fsm_ctrl: expected post-edge state per cycle
// is queued by the driver and compared by a monitor just after each clock edge.
module tb_router_fsm_ctrl;
  import router_pkg::*;

  logic       clk = 1'b0;
  logic       rst, pkt_valid, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_full_in, fifo_empty, read_enb;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic       write_enb_reg, fifo_full, busy;
  logic [2:0] write_enb, vld_out, soft_reset;
`ifdef ROUTER_ADDR_ERR_EN
  logic       addr_err;
`endif

  always #5 clk = ~clk;

  router_fsm_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full_in  (fifo_full_in),
    .fifo_empty    (fifo_empty),
    .read_enb      (read_enb),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .write_enb_reg (write_enb_reg),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .busy          (busy),
    .vld_out       (vld_out),
    .soft_reset    (soft_reset)
`ifdef ROUTER_ADDR_ERR_EN
    ,
    .addr_err      (addr_err)
`endif
  );

  typedef struct {
    string      tag;
    state_e     st;
    logic [1:0] sel;
    logic [2:0] sr;
    logic       ff;
    logic [2:0] vo;
    logic       ae;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [5:0] dec6(input state_e s);
    case (s)
      DECODE_ADDRESS:     return 6'b100000;
      LOAD_FIRST_DATA:    return 6'b010000;
      LOAD_DATA:          return 6'b001000;
      LOAD_AFTER_FULL:    return 6'b000100;
      FIFO_FULL_STATE:    return 6'b000010;
      CHECK_PARITY_ERROR: return 6'b000001;
      default:            return 6'b000000;
    endcase
  endfunction

  function automatic logic wer_of(input state_e s);
    return (s == LOAD_DATA) || (s == LOAD_PARITY) || (s == LOAD_AFTER_FULL);
  endfunction

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      check({cur.tag, ".dec"}, 8'({detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg}),
            8'(dec6(cur.st)));
      check({cur.tag, ".busy"}, 8'(busy), 8'(!(cur.st == DECODE_ADDRESS || cur.st == LOAD_DATA)));
      check({cur.tag, ".wer"}, 8'(write_enb_reg), 8'(wer_of(cur.st)));
      check({cur.tag, ".we"}, 8'(write_enb), wer_of(cur.st) ? (8'd1 << cur.sel) : 8'd0);
      check({cur.tag, ".ff"}, 8'(fifo_full), 8'(cur.ff));
      check({cur.tag, ".vld"}, 8'(vld_out), 8'(cur.vo));
      check({cur.tag, ".sr"}, 8'(soft_reset), 8'(cur.sr));
`ifdef ROUTER_ADDR_ERR_EN
      check({cur.tag, ".ae"}, 8'(addr_err), 8'(cur.ae));
`endif
    end
  end

  // Queue what the outputs must look like after the coming edge, then advance one cycle.
  task automatic tick(input string tag, input state_e st, input logic [1:0] sel,
                      input logic [2:0] sr, input logic ae = 1'b0);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.sel = sel;
    e.sr  = sr;
    e.ff  = fifo_full_in[sel];
    e.vo  = ~fifo_empty;
    e.ae  = ae;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; pkt_valid = 1'b0; data_in = 2'd0;
    fifo_full_in = 3'b000; fifo_empty = 3'b111; read_enb = 3'b000;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    tick("rst", DECODE_ADDRESS, 2'd0, 3'b000);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick("idle", DECODE_ADDRESS, 2'd0, 3'b000);

    // Port 1 packet: header, 4 payload bytes, parity.
    pkt_valid = 1'b1; data_in = 2'd1;
    tick("a1_hdr", LOAD_FIRST_DATA, 2'd1, 3'b000);
    for (int i = 0; i < 4; i++) tick("a1_ld", LOAD_DATA, 2'd1, 3'b000);
    pkt_valid = 1'b0;
    tick("a1_last", LOAD_PARITY, 2'd1, 3'b000);
    tick("a1_lp", CHECK_PARITY_ERROR, 2'd1, 3'b000);
    tick("a1_cpe", DECODE_ADDRESS, 2'd1, 3'b000);

    // Port 2 busy for 5 cycles before the packet may start.
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
    for (int i = 0; i < 5; i++) tick("a2_wte", WAIT_TILL_EMPTY, 2'd2, 3'b000);
    fifo_empty = 3'b111;
    tick("a2_go", LOAD_FIRST_DATA, 2'd2, 3'b000);
    tick("a2_lfd", LOAD_DATA, 2'd2, 3'b000);
    pkt_valid = 1'b0;
    tick("a2_lp", LOAD_PARITY, 2'd2, 3'b000);
    tick("a2_cpe", CHECK_PARITY_ERROR, 2'd2, 3'b000);
    tick("a2_da", DECODE_ADDRESS, 2'd2, 3'b000);

    // Port 0 with FIFO-full stalls through LD, CPE and LAF exits.
    pkt_valid = 1'b1; data_in = 2'd0;
    tick("f_hdr", LOAD_FIRST_DATA, 2'd0, 3'b000);
    tick("f_ld", LOAD_DATA, 2'd0, 3'b000);
    tick("f_ld", LOAD_DATA, 2'd0, 3'b000);
    fifo_full_in = 3'b001;
    for (int i = 0; i < 3; i++) tick("f_ffs", FIFO_FULL_STATE, 2'd0, 3'b000);
    fifo_full_in = 3'b000;
    tick("f_laf", LOAD_AFTER_FULL, 2'd0, 3'b000);
    tick("f_laf_ld", LOAD_DATA, 2'd0, 3'b000);
    tick("f_ld2", LOAD_DATA, 2'd0, 3'b000);
    fifo_full_in = 3'b001;
    tick("f_ffs2", FIFO_FULL_STATE, 2'd0, 3'b000);
    fifo_full_in = 3'b000;
    tick("f_laf2", LOAD_AFTER_FULL, 2'd0, 3'b000);
    pkt_valid = 1'b0; low_pkt_valid = 1'b1;
    tick("f_laf_lp", LOAD_PARITY, 2'd0, 3'b000);
    low_pkt_valid = 1'b0; fifo_full_in = 3'b001;
    tick("f_lp", CHECK_PARITY_ERROR, 2'd0, 3'b000);
    tick("f_cpe_full", FIFO_FULL_STATE, 2'd0, 3'b000);
    fifo_full_in = 3'b000;
    tick("f_laf3", LOAD_AFTER_FULL, 2'd0, 3'b000);
    parity_done = 1'b1;
    tick("f_laf_da", DECODE_ADDRESS, 2'd0, 3'b000);
    parity_done = 1'b0;

    // Reset mid-packet returns straight to DA with sel cleared.
    pkt_valid = 1'b1; data_in = 2'd2;
    tick("r_hdr", LOAD_FIRST_DATA, 2'd2, 3'b000);
    tick("r_ld", LOAD_DATA, 2'd2, 3'b000);
    rst = 1'b1;
    tick("r_mid", DECODE_ADDRESS, 2'd0, 3'b000);
    rst = 1'b0; pkt_valid = 1'b0;

    // Port 1 unread for 30 cycles while a packet to port 1 is in LD.
    pkt_valid = 1'b1; data_in = 2'd1;
    tick("to_hdr", LOAD_FIRST_DATA, 2'd1, 3'b000);
    fifo_empty = 3'b101;
    for (int k = 1; k <= 29; k++) tick("to_ld", LOAD_DATA, 2'd1, 3'b000);
    tick("to_pulse", LOAD_DATA, 2'd1, 3'b010);
    tick("to_flush", DECODE_ADDRESS, 2'd1, 3'b000);
    pkt_valid = 1'b0;
    tick("to_idle", DECODE_ADDRESS, 2'd1, 3'b000);
    fifo_empty = 3'b111;
    tick("to_clr", DECODE_ADDRESS, 2'd1, 3'b000);

    // Same again with a read at cycle 20: the pulse must not come.
    fifo_empty = 3'b101;
    for (int k = 1; k <= 40; k++) begin
      read_enb = (k == 20) ? 3'b010 : 3'b000;
      tick("to_cancel", DECODE_ADDRESS, 2'd1, 3'b000);
    end
    read_enb = 3'b000; fifo_empty = 3'b111;

    // Invalid header address 3.
    pkt_valid = 1'b1; data_in = 2'd3;
    tick("inv", DECODE_ADDRESS, 2'd1, 3'b000, 1'b1);
    pkt_valid = 1'b0;
    tick("inv_after", DECODE_ADDRESS, 2'd1, 3'b000, 1'b0);

    check("queue_drain", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
